ld_st_control_sequencer: RTL and testbench
==========================================

Name: ld_st_control_sequencer

Overview:
- Hardwired control sequencer that drives the datapath control strobes for fetch plus the load/store class (ld, ldi, st). It replaces hand-sequenced testbench stimulus.
- Adds a memory-ready handshake with timeout, illegal-opcode detection, run/idle control and a retired-instruction counter.
- Sits beside the datapath. It consumes the IR opcode field and drives the datapath's control inputs.

Parameters:
- OPCODE_W, 5, width of the IR opcode field
- OP_LD, 5'b00000, opcode for ld Ra,C(Rb)
- OP_LDI, 5'b00001, opcode for ldi Ra,C(Rb)
- OP_ST, 5'b00010, opcode for st C(Rb),Ra
- MEM_TIMEOUT, 15, max cycles waiting on mem_ready before fault (must be ≥1)
- CNT_W, 16, width of instr_count

Ports:
- clock  in  1  system clock
- clear  in  1  reset; synchronous and active-high
- run  in  1  level; permits starting the next instruction
- ir_op  in  OPCODE_W  opcode field of the IR; valid from T3
- mem_ready  in  1  RAM access completes at this edge
- PCout, MARin, IncPC, Zlowin, Zlowout, PCin  out  1 each  datapath strobes
- MDMuxread, RAMread, RAMwrite, MDRin, MDRout, IRin  out  1 each  memory-path strobes
- Gra, Grb, Rin, Rout, BAout, Yin, CSEout, ADD  out  1 each  register-select and ALU strobes
- busy  out  1  high in any state except IDLE and FAULT
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- fault  out  1  sticky memory-timeout flag
- instr_count  out  CNT_W  retired legal instructions; wraps

Behaviour:
- Reset:
  - Synchronous: clear sampled high at a clock edge forces state=IDLE, wait_cnt=0, instr_count=0 and fault=0.
  - All strobes, busy and illegal_op are 0 while in IDLE.
  - Reset mid-instruction aborts immediately; no partial completion and no count increment.
- Output style: Moore. Strobes are a pure function of the registered state and the opcode latched at T3 (op_q). Each strobe is held for every cycle the state is occupied.
- States: IDLE, T0–T7, FAULT.
- IDLE: go to T0 when run=1.
- Fetch steps (all opcodes):
  - T0: PCout MARin IncPC Zlowin.
  - T1: Zlowout PCin MDMuxread RAMread MDRin. This is a wait state. Repeated PCin/MDRin are idempotent.
  - T2: MDRout IRin.
- T3 (all legal opcodes): Grb BAout Yin. op_q <= ir_op.
  - If ir_op is not in {OP_LD, OP_LDI, OP_ST}: all T3 strobes are suppressed, illegal_op=1 for this cycle, and the next state is T0 if run, else IDLE. instr_count is unchanged.
- T4: CSEout ADD Zlowin.
- T5:
  - ld/st: Zlowout MARin.
  - ldi: Zlowout Gra Rin. ldi completes here.
- T6:
  - ld: MDMuxread RAMread MDRin. This is a wait state.
  - st: Gra Rout MDRin, with MDMuxread=0.
- T7:
  - ld: MDRout Gra Rin. ld completes here.
  - st: RAMwrite. This is a wait state; st completes here.
- Wait states are T1, ld-T6 and st-T7:
  - The state advances at the first edge where mem_ready=1. The strobes stay asserted until that edge.
  - wait_cnt clears on entry to the state and increments each cycle with mem_ready=0.
  - If wait_cnt reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT.
  - mem_ready=1 on the same edge as the timeout wins: the state advances.
- Completion: instr_count increments (mod 2^CNT_W) on the completion edge. The next state is T0 if run, else IDLE. Back-to-back instructions have no idle bubble.
- FAULT: all strobes are 0 and fault=1. FAULT is left only via clear.
- Latency with mem_ready=1 always: ld 8 cycles, ldi 6 cycles, st 8 cycles, illegal opcode 4 cycles.
- run going low mid-instruction does not abort; it is only sampled at IDLE and on completion.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After each completion or illegal-opcode exit, the sequencer always returns to IDLE.
  - IDLE is left only on an edge with run=1 and step=1.
  - A step held high starts exactly one instruction per IDLE visit.
- Undefined: no step port; behaviour exactly as above.

Decomposition:
- Package ld_st_ctrl_pkg holds:
  - the state enum (4-bit encoding: IDLE=0, T0..T7=1..8, FAULT=15);
  - default opcode constants;
  - a packed struct bundling the 20 strobes, so the output decode is one assignment.
- One natural sub-module: mem_wait_timer (wait_cnt, clear-on-entry, timeout compare), reused for all three wait states.

Test Plan:
- clear for 2 cycles, then run=1, ir_op=OP_LD, mem_ready=1 -> states T0..T7 in 8 consecutive cycles, each strobe set exactly per step, instr_count=1, next state T0.
- ir_op=OP_LDI, run dropped during T4 -> T5 shows Zlowout Gra Rin, then IDLE; instr_count +1; 6 cycles total.
- ir_op=OP_ST, mem_ready low for 3 cycles in T7 -> RAMwrite high for exactly 4 cycles; T6 has Rout=1 and MDMuxread=0.
- mem_ready held 0 in T1 with MEM_TIMEOUT=15 -> FAULT after 15 wait cycles; fault=1, busy=0, all strobes 0; stays in FAULT until clear.
- ir_op=5'b11111 -> illegal_op one-cycle pulse in T3, Grb/BAout/Yin=0, then T0; instr_count unchanged.
- clear asserted in ld-T6 -> IDLE at the next edge, all outputs 0, instr_count=0; with CTRL_SINGLE_STEP_EN, run=1 and step=0 -> remains in IDLE.

Source files
------------

// File: rtl/ld_st_control_sequencer_pkg.sv
// ld_st_ctrl_pkg: state encoding, default opcodes and strobe bundle for the ld/st sequencer
package ld_st_ctrl_pkg;
  localparam int DEF_OPCODE_W = 5;
  localparam logic [4:0] DEF_OP_LD = 5'b00000;
  localparam logic [4:0] DEF_OP_LDI = 5'b00001;
  localparam logic [4:0] DEF_OP_ST = 5'b00010;
  localparam int DEF_MEM_TIMEOUT = 15;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_FAULT = 4'd15
  } state_e;
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic zlow_in;
    logic zlow_out;
    logic pc_in;
    logic mdmux_read;
    logic ram_read;
    logic ram_write;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic grb;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic y_in;
    logic cse_out;
    logic add;
  } strobes_t;
endpackage

// File: rtl/ld_st_control_sequencer_mem_wait_timer.sv
// mem_wait_timer: counts stalled memory-wait cycles and flags the timeout edge
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait,
  input  logic mem_ready,
  output logic timeout
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] wait_cnt_q, wait_cnt_d;
  logic stall;
  // Any non-stalled cycle zeroes the count, so every wait state is entered at zero
  always_comb begin
    stall = in_wait && !mem_ready;
    wait_cnt_d = stall ? wait_cnt_q + W'(1) : '0;
    timeout = stall && (wait_cnt_q == W'(TIMEOUT - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else wait_cnt_q <= wait_cnt_d;
  end
endmodule

// File: rtl/ld_st_control_sequencer.sv
// ld_st_control_sequencer: fetch + ld/ldi/st control strobe sequencer (optional CTRL_SINGLE_STEP_EN adds step port)
module ld_st_control_sequencer
  import ld_st_ctrl_pkg::*;
#(
  parameter int OPCODE_W = DEF_OPCODE_W,
  parameter logic [OPCODE_W-1:0] OP_LD = OPCODE_W'(DEF_OP_LD),
  parameter logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(DEF_OP_LDI),
  parameter logic [OPCODE_W-1:0] OP_ST = OPCODE_W'(DEF_OP_ST),
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clock,
  input  logic clear,
  input  logic run,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic step,
`endif
  input  logic [OPCODE_W-1:0] ir_op,
  input  logic mem_ready,
  output logic PCout, MARin, IncPC, Zlowin, Zlowout, PCin,
  output logic MDMuxread, RAMread, RAMwrite, MDRin, MDRout, IRin,
  output logic Gra, Grb, Rin, Rout, BAout, Yin, CSEout, ADD,
  output logic busy,
  output logic illegal_op,
  output logic fault,
  output logic [CNT_W-1:0] instr_count
);
  state_e state_q, state_d, after;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  strobes_t strb;
  logic legal, is_ld, is_ldi, in_wait, timeout, done, go, cont;
`ifdef CTRL_SINGLE_STEP_EN
  assign go = run && step;
  assign cont = 1'b0;
`else
  assign go = run;
  assign cont = run;
`endif
  assign legal = (ir_op == OP_LD) || (ir_op == OP_LDI) || (ir_op == OP_ST);
  assign is_ld = op_q == OP_LD;
  assign is_ldi = op_q == OP_LDI;
  assign after = cont ? S_T0 : S_IDLE;
  assign in_wait = (state_q == S_T1) || (state_q == S_T6 && is_ld) || (state_q == S_T7 && !is_ld);
  assign done = (state_q == S_T5 && is_ldi) || (state_q == S_T7 && (is_ld || mem_ready));
  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clock),
    .rst(clear),
    .in_wait(in_wait),
    .mem_ready(mem_ready),
    .timeout(timeout)
  );
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      op_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    op_d = (state_q == S_T3) ? ir_op : op_q;
    cnt_d = done ? cnt_q + CNT_W'(1) : cnt_q;
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = go ? S_T0 : S_IDLE;
      S_T0: state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: state_d = legal ? S_T4 : after;
      S_T4: state_d = S_T5;
      S_T5: state_d = is_ldi ? after : S_T6;
      S_T6: state_d = S_T7;
      S_T7: state_d = after;
      default: state_d = state_q;
    endcase
    // A stalled wait state holds its strobes until ready or the timeout fires
    if (in_wait && !mem_ready) state_d = timeout ? S_FAULT : state_q;
  end
  always_comb begin
    strb = '0;
    case (state_q)
      S_T0: begin
        strb.pc_out = 1'b1;
        strb.mar_in = 1'b1;
        strb.inc_pc = 1'b1;
        strb.zlow_in = 1'b1;
      end
      S_T1: begin
        strb.zlow_out = 1'b1;
        strb.pc_in = 1'b1;
        strb.mdmux_read = 1'b1;
        strb.ram_read = 1'b1;
        strb.mdr_in = 1'b1;
      end
      S_T2: begin
        strb.mdr_out = 1'b1;
        strb.ir_in = 1'b1;
      end
      S_T3: begin
        strb.grb = legal;
        strb.ba_out = legal;
        strb.y_in = legal;
      end
      S_T4: begin
        strb.cse_out = 1'b1;
        strb.add = 1'b1;
        strb.zlow_in = 1'b1;
      end
      S_T5: begin
        strb.zlow_out = 1'b1;
        strb.mar_in = !is_ldi;
        strb.gra = is_ldi;
        strb.r_in = is_ldi;
      end
      S_T6: begin
        strb.mdr_in = 1'b1;
        strb.mdmux_read = is_ld;
        strb.ram_read = is_ld;
        strb.gra = !is_ld;
        strb.r_out = !is_ld;
      end
      S_T7: begin
        strb.mdr_out = is_ld;
        strb.gra = is_ld;
        strb.r_in = is_ld;
        strb.ram_write = !is_ld;
      end
      default: strb = '0;
    endcase
  end
  assign {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDMuxread, RAMread, RAMwrite, MDRin,
          MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, CSEout, ADD} = strb;
  assign busy = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign illegal_op = (state_q == S_T3) && !legal;
  assign fault = state_q == S_FAULT;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_ld_st_control_sequencer.sv
// tb_ld_st_control_sequencer: directed checks of fetch, ld/ldi/st, stalls, timeout, illegal opcode, clear
module tb_ld_st_control_sequencer;
  logic clock = 1'b0;
  logic clear, run, mem_ready;
  logic [4:0] ir_op;
  logic PCout, MARin, IncPC, Zlowin, Zlowout, PCin;
  logic MDMuxread, RAMread, RAMwrite, MDRin, MDRout, IRin;
  logic Gra, Grb, Rin, Rout, BAout, Yin, CSEout, ADD;
  logic busy, illegal_op, fault;
  logic [15:0] instr_count;
  logic [31:0] strb;
`ifdef CTRL_SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  int n_checks = 0;
  int n_fail = 0;
  // bit order: PCout MARin IncPC Zlowin Zlowout PCin MDMuxread RAMread RAMwrite MDRin MDRout IRin Gra Grb Rin Rout BAout Yin CSEout ADD
  localparam logic [31:0] ST0 = 32'hF0000;
  localparam logic [31:0] ST1 = 32'h0F400;
  localparam logic [31:0] ST2 = 32'h00300;
  localparam logic [31:0] ST3 = 32'h0004C;
  localparam logic [31:0] ST4 = 32'h10003;
  localparam logic [31:0] ST5_LS = 32'h48000;
  localparam logic [31:0] ST5_LDI = 32'h080A0;
  localparam logic [31:0] ST6_LD = 32'h03400;
  localparam logic [31:0] ST6_ST = 32'h00490;
  localparam logic [31:0] ST7_LD = 32'h002A0;
  localparam logic [31:0] ST7_ST = 32'h00800;
  localparam logic [4:0] OP_LD = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST = 5'b00010;
  assign strb = {12'b0, PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDMuxread, RAMread, RAMwrite, MDRin,
                 MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, CSEout, ADD};
  always #5 clock = ~clock;
  ld_st_control_sequencer dut (
    .clock(clock), .clear(clear), .run(run),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .ir_op(ir_op), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin), .Zlowout(Zlowout), .PCin(PCin),
    .MDMuxread(MDMuxread), .RAMread(RAMread), .RAMwrite(RAMwrite), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Yin(Yin), .CSEout(CSEout), .ADD(ADD),
    .busy(busy), .illegal_op(illegal_op), .fault(fault), .instr_count(instr_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] ld_seq[8] = '{ST0, ST1, ST2, ST3, ST4, ST5_LS, ST6_LD, ST7_LD};
    logic [31:0] ldi_seq[5] = '{ST1, ST2, ST3, ST4, ST5_LDI};
    logic [31:0] st_seq[7] = '{ST0, ST1, ST2, ST3, ST4, ST5_LS, ST6_ST};
    logic [31:0] ill_seq[3] = '{ST1, ST2, 32'h0};
    clear = 1'b1; run = 1'b0; ir_op = '0; mem_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_strb", strb, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_ill", 32'(illegal_op), 0);
    check("rst_cnt", 32'(instr_count), 0);
    clear = 1'b0; run = 1'b1; ir_op = OP_LD;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check($sformatf("ld_t%0d", i), strb, ld_seq[i]);
      check($sformatf("ld_busy_t%0d", i), 32'(busy), 1);
    end
    check("ld_cnt_t7", 32'(instr_count), 0);
    @(negedge clock);
    check("ld_next_t0", strb, ST0);
    check("ld_cnt", 32'(instr_count), 1);
    ir_op = OP_LDI;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("ldi_t%0d", i + 1), strb, ldi_seq[i]);
      if (i == 3) run = 1'b0;
    end
    check("ldi_cnt_t5", 32'(instr_count), 1);
    @(negedge clock);
    check("ldi_idle_strb", strb, 0);
    check("ldi_idle_busy", 32'(busy), 0);
    check("ldi_cnt", 32'(instr_count), 2);
    ir_op = OP_ST; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      check($sformatf("st_t%0d", i), strb, st_seq[i]);
    end
    check("st_t6_rout", 32'(Rout), 1);
    check("st_t6_mdmux", 32'(MDMuxread), 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("st_t7_c%0d", i + 1), strb, ST7_ST);
      if (i == 3) mem_ready = 1'b1;
    end
    @(negedge clock);
    check("st_next_t0", strb, ST0);
    check("st_ramwrite_off", 32'(RAMwrite), 0);
    check("st_cnt", 32'(instr_count), 3);
    ir_op = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("ill_t%0d", i + 1), strb, ill_seq[i]);
      check($sformatf("ill_pulse_t%0d", i + 1), 32'(illegal_op), (i == 2) ? 1 : 0);
    end
    check("ill_busy", 32'(busy), 1);
    @(negedge clock);
    check("ill_next_t0", strb, ST0);
    check("ill_pulse_end", 32'(illegal_op), 0);
    check("ill_cnt", 32'(instr_count), 3);
    ir_op = OP_LD; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      check($sformatf("to_t1_c%0d", i + 1), strb, ST1);
    end
    @(negedge clock);
    check("to_fault", 32'(fault), 1);
    check("to_busy", 32'(busy), 0);
    check("to_strb", strb, 0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("to_sticky", 32'(fault), 1);
    check("to_sticky_strb", strb, 0);
    clear = 1'b1;
    @(negedge clock);
    check("clr_fault", 32'(fault), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_cnt", 32'(instr_count), 0);
    clear = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
    check("tie_t0", strb, ST0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      check($sformatf("tie_t1_c%0d", i + 1), strb, ST1);
      if (i == 14) mem_ready = 1'b1;
    end
    @(negedge clock);
    check("tie_t2", strb, ST2);
    check("tie_no_fault", 32'(fault), 0);
    @(negedge clock);
    check("tie_t3", strb, ST3);
    @(negedge clock);
    check("tie_t4", strb, ST4);
    @(negedge clock);
    check("tie_t5", strb, ST5_LS);
    @(negedge clock);
    check("tie_t6", strb, ST6_LD);
    clear = 1'b1;
    @(negedge clock);
    check("abort_strb", strb, 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_cnt", 32'(instr_count), 0);
    clear = 1'b0; run = 1'b0;
    @(negedge clock);
    check("abort_stay_idle", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
